// File: rtl/exec_sequencer.sv
// exec_sequencer
//    Multi-cycle control FSM for the processor datapath. Owns the program
//    counter and steps one instruction at a time through
//    FETCH -> DECODE -> EXEC -> WAIT_ALU -> WB, with a start/done handshake
//    toward the ALU and a St/done handshake toward the outside world.
//
// Optional feature macro: SEQ_SINGLE_STEP_EN
//    When defined, adds input port `step` and state STEP_WAIT. After each
//    writeback the FSM parks in STEP_WAIT (enable stays high) until a step
//    pulse. The end-of-memory check still goes straight to HALT.
//
// Ports
//    CLK          in   rising-edge clock
//    RSTn         in   asynchronous active-low reset
//    St           in   start request, honoured only in IDLE or HALT
//    instr        in   instruction word at address pc
//    halt_instr   in   decoder flag: ir holds a halt opcode
//    jump         in   take jump_target at writeback
//    jump_target  in   byte address of the jump target
//    alu_done     in   ALU completion pulse, only looked at in WAIT_ALU
//    step         in   (SEQ_SINGLE_STEP_EN only) advance out of STEP_WAIT
//    pc           out  program counter (byte address)
//    ir           out  latched instruction register
//    alu_start    out  one-cycle ALU launch pulse (EXEC)
//    reg_we       out  one-cycle register-file write enable (WB)
//    enable       out  high while a program is running
//    done         out  high in HALT
//    err          out  high in HALT if the run aborted on ALU timeout
//    retired      out  instructions written back since the last start

module exec_sequencer #(
   parameter int PC_W        = 32,
   parameter int IMEM_DEPTH  = 32,
   parameter int ALU_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             St,
   input  logic [31:0]      instr,
   input  logic             halt_instr,
   input  logic             jump,
   input  logic [PC_W-1:0]  jump_target,
   input  logic             alu_done,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic             step,
`endif
   output logic [PC_W-1:0]  pc,
   output logic [31:0]      ir,
   output logic             alu_start,
   output logic             reg_we,
   output logic             enable,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] retired
);

   localparam int TO_W = $clog2(ALU_TIMEOUT + 1) + 1;
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(ALU_TIMEOUT - 1);
   // One extra bit so the end-of-memory compare cannot wrap.
   localparam logic [PC_W:0]   END_ADDR = (PC_W + 1)'(4 * IMEM_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FETCH    = 3'd1,
      S_DECODE   = 3'd2,
      S_EXEC     = 3'd3,
      S_WAIT_ALU = 3'd4,
      S_WB       = 3'd5,
      S_HALT     = 3'd6
`ifdef SEQ_SINGLE_STEP_EN
      , S_STEP_WAIT = 3'd7
`endif
   } state_t;

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  retired_q, retired_d;
   logic [TO_W-1:0]   cnt_q, cnt_d;

   logic [PC_W-1:0]   pc_wb_s;
   logic              pc_end_s;
   logic [TO_W-1:0]   cnt_inc_s;

   // Writeback pc candidate and end-of-memory detection.
   always_comb begin
      if (jump) begin
         pc_wb_s = {jump_target[PC_W-1:2], 2'b00};
      end else begin
         pc_wb_s = pc_q + PC_W'(4);
      end
      pc_end_s  = ({1'b0, pc_wb_s} >= END_ADDR);
      cnt_inc_s = cnt_q + TO_W'(1);
   end

   // Next-state and datapath-register update logic.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      err_d     = err_q;
      retired_d = retired_q;
      cnt_d     = cnt_q;
      case (state_q)
         S_IDLE, S_HALT: begin
            if (St) begin
               state_d   = S_FETCH;
               pc_d      = '0;
               retired_d = '0;
               err_d     = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         S_FETCH: begin
            ir_d    = instr;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            // A halt opcode stops the run without being counted as retired.
            if (halt_instr) begin
               state_d = S_HALT;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            cnt_d   = '0;
            state_d = S_WAIT_ALU;
         end
         S_WAIT_ALU: begin
            // alu_done beats the timeout when both land in the same cycle.
            if (alu_done) begin
               state_d = S_WB;
            end else begin
               cnt_d = cnt_inc_s;
               if (cnt_inc_s >= TO_LAST) begin
                  state_d = S_HALT;
                  err_d   = 1'b1;
               end else begin
                  state_d = state_q;
               end
            end
         end
         S_WB: begin
            pc_d = pc_wb_s;
            if (retired_q != {CNT_W{1'b1}}) begin
               retired_d = retired_q + CNT_W'(1);
            end else begin
               retired_d = retired_q;
            end
            if (pc_end_s) begin
               state_d = S_HALT;
            end else begin
`ifdef SEQ_SINGLE_STEP_EN
               state_d = S_STEP_WAIT;
`else
               state_d = S_FETCH;
`endif
            end
         end
`ifdef SEQ_SINGLE_STEP_EN
         S_STEP_WAIT: begin
            if (step) begin
               state_d = S_FETCH;
            end else begin
               state_d = state_q;
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         ir_q      <= 32'h0000_0000;
         err_q     <= 1'b0;
         retired_q <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         err_q     <= err_d;
         retired_q <= retired_d;
         cnt_q     <= cnt_d;
      end
   end

   // Moore outputs decoded straight from the state register.
   always_comb begin
      pc        = pc_q;
      ir        = ir_q;
      err       = err_q;
      retired   = retired_q;
      alu_start = (state_q == S_EXEC);
      reg_we    = (state_q == S_WB);
      done      = (state_q == S_HALT);
      enable    = (state_q != S_IDLE) && (state_q != S_HALT);
   end

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: the main sequence pushes expected
// writeback / halt events, an independent monitor pops and compares them
// whenever the DUT pulses reg_we or raises done.

module tb_exec_sequencer;

   localparam int PC_W        = 32;
   localparam int IMEM_DEPTH  = 32;
   localparam int ALU_TIMEOUT = 16;
   localparam int CNT_W       = 16;
   localparam logic [31:0] HALT_OP = 32'hFFFF_FFFF;

   logic             CLK = 1'b0;
   logic             RSTn = 1'b0;
   logic             St = 1'b0;
   logic [31:0]      instr;
   logic             halt_instr;
   logic             jump;
   logic [PC_W-1:0]  jump_target;
   logic             alu_done;
   logic [PC_W-1:0]  pc;
   logic [31:0]      ir;
   logic             alu_start;
   logic             reg_we;
   logic             enable;
   logic             done;
   logic             err;
   logic [CNT_W-1:0] retired;

   logic [31:0] imem [0:IMEM_DEPTH-1];
   logic alu_en = 1'b0;
   logic alu_done_m = 1'b0;
   logic alu_done_f = 1'b0;
   logic alu_pend = 1'b0;

   int errors = 0;
   int checks = 0;
   int n_start = 0;
   int n_we = 0;

   typedef struct {
      bit          is_halt;
      logic [31:0] pc;
      logic [31:0] ir;
      logic [31:0] retired;
      logic        err;
   } exp_t;
   exp_t sb_q[$];

`ifdef SEQ_SINGLE_STEP_EN
   logic step_auto = 1'b1;
   logic step_m = 1'b0;
   logic step;
   assign step = step_auto | step_m;
`endif

   always #5 CLK = ~CLK;

   // Instruction memory and a tiny decoder in the bench.
   assign instr       = (pc < 32'(4 * IMEM_DEPTH)) ? imem[pc[6:2]] : 32'h0000_0000;
   assign halt_instr  = (ir == HALT_OP);
   assign jump        = (ir[31:28] == 4'hA);
   assign jump_target = {4'h0, ir[27:0]};
   assign alu_done    = alu_done_m | alu_done_f;

   exec_sequencer #(
      .PC_W(PC_W), .IMEM_DEPTH(IMEM_DEPTH), .ALU_TIMEOUT(ALU_TIMEOUT), .CNT_W(CNT_W)
   ) dut (
      .CLK(CLK), .RSTn(RSTn), .St(St), .instr(instr), .halt_instr(halt_instr),
      .jump(jump), .jump_target(jump_target), .alu_done(alu_done),
`ifdef SEQ_SINGLE_STEP_EN
      .step(step),
`endif
      .pc(pc), .ir(ir), .alu_start(alu_start), .reg_we(reg_we),
      .enable(enable), .done(done), .err(err), .retired(retired)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_wb(input logic [31:0] p, input logic [31:0] i);
      exp_t e;
      e.is_halt = 1'b0; e.pc = p; e.ir = i; e.retired = 32'h0; e.err = 1'b0;
      sb_q.push_back(e);
   endtask

   task automatic push_halt(input logic [31:0] p, input logic [31:0] r, input logic e_err);
      exp_t e;
      e.is_halt = 1'b1; e.pc = p; e.ir = 32'h0; e.retired = r; e.err = e_err;
      sb_q.push_back(e);
   endtask

   task automatic clear_imem(); // unused words halt the program quickly
      for (int i = 0; i < IMEM_DEPTH; i++) imem[i] = HALT_OP;
   endtask

   task automatic load_basic();
      clear_imem();
      imem[0] = 32'h0000_0011;
      imem[1] = 32'h0000_0022;
      imem[2] = 32'h0000_0033;
      imem[3] = HALT_OP;
   endtask

   task automatic pulse_start();
      St = 1'b1;
      @(negedge CLK);
      St = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      for (int n = 0; n < budget; n++) begin
         if (done) break;
         @(negedge CLK);
      end
      check(name, 32'(done), 32'h1);
      #1;
   endtask

   // ALU model: alu_done pulses one cycle after alu_start when enabled.
   initial begin
      forever begin
         @(negedge CLK);
         alu_done_m = 1'b0;
         if (alu_pend) begin
            alu_done_m = 1'b1;
            alu_pend = 1'b0;
         end
         if (alu_start && alu_en) alu_pend = 1'b1;
      end
   end

   // Monitor: pops expectations on each writeback and on each entry to HALT.
   initial begin
      logic done_prev;
      exp_t e;
      done_prev = 1'b0;
      forever begin
         @(negedge CLK);
         if (!RSTn) begin
            done_prev = 1'b0;
         end else begin
            if (alu_start) n_start++;
            if (reg_we) begin
               n_we++;
               if (sb_q.size() == 0 || sb_q[0].is_halt) begin
                  checks++; errors++;
                  $display("FAIL unexpected_wb: got writeback at pc %h, expected none", pc);
                  if (sb_q.size() != 0) void'(sb_q.pop_front());
               end else begin
                  e = sb_q.pop_front();
                  check("wb_pc", pc, e.pc);
                  check("wb_ir", ir, e.ir);
               end
            end
            if (done && !done_prev) begin
               if (sb_q.size() == 0 || !sb_q[0].is_halt) begin
                  checks++; errors++;
                  $display("FAIL unexpected_halt: got halt at pc %h, expected none", pc);
                  if (sb_q.size() != 0) void'(sb_q.pop_front());
               end else begin
                  e = sb_q.pop_front();
                  check("halt_pc", pc, e.pc);
                  check("halt_retired", 32'(retired), e.retired);
                  check("halt_err", 32'(err), 32'(e.err));
               end
            end
            done_prev = done;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      clear_imem();
      // Reset values.
      repeat (2) @(negedge CLK);
      check("rst_pc", pc, 32'h0);
      check("rst_ir", ir, 32'h0);
      check("rst_flags", {26'h0, alu_start, reg_we, enable, done, err, 1'b0}, 32'h0);
      check("rst_retired", 32'(retired), 32'h0);
      RSTn = 1'b1;
      @(negedge CLK);

      // Three ALU ops then halt at word 3.
      load_basic();
      alu_en = 1'b1;
      n_start = 0; n_we = 0;
      push_wb(32'h0, 32'h11); push_wb(32'h4, 32'h22); push_wb(32'h8, 32'h33);
      push_halt(32'hC, 32'd3, 1'b0);
      pulse_start();
      check("run_enable", 32'(enable), 32'h1);
      wait_done("basic_done", 200);
      check("basic_alu_starts", 32'(n_start), 32'd3);
      check("basic_reg_we", 32'(n_we), 32'd3);
      check("basic_enable_low", 32'(enable), 32'h0);
      check("basic_sb_empty", 32'(sb_q.size()), 32'h0);

      // Jump to 0xE lands on 0xC (word 3); restart from HALT.
      clear_imem();
      imem[0] = 32'hA000_000E;
      imem[3] = 32'h0000_0044;
      imem[4] = HALT_OP;
      push_wb(32'h0, 32'hA000_000E); push_wb(32'hC, 32'h44);
      push_halt(32'h10, 32'd2, 1'b0);
      pulse_start();
      check("restart_done_low", 32'(done), 32'h0);
      wait_done("jump_done", 200);
      check("jump_sb_empty", 32'(sb_q.size()), 32'h0);

      // ALU never answers: HALT 16 cycles after alu_start with err.
      clear_imem();
      imem[0] = 32'h0000_0055;
      alu_en = 1'b0;
      n_we = 0;
      push_halt(32'h0, 32'd0, 1'b1);
      pulse_start();
      for (n = 0; n < 20 && !alu_start; n++) @(negedge CLK);
      check("to_saw_start", 32'(alu_start), 32'h1);
      for (n = 1; n < 40; n++) begin
         @(negedge CLK);
         if (done) break;
      end
      check("to_latency", 32'(n), 32'd16);
      #1;
      check("to_err", 32'(err), 32'h1);
      check("to_no_we", 32'(n_we), 32'h0);
      check("to_sb_empty", 32'(sb_q.size()), 32'h0);

      // No halt opcode: runs off the end of memory.
      @(negedge CLK);
      for (int i = 0; i < IMEM_DEPTH; i++) imem[i] = 32'h0000_0100 + 32'(i);
      alu_en = 1'b1;
      for (int i = 0; i < IMEM_DEPTH; i++) push_wb(32'(4 * i), 32'h0000_0100 + 32'(i));
      push_halt(32'd128, 32'd32, 1'b0);
      pulse_start();
      check("end_err_cleared", 32'(err), 32'h0);
      wait_done("end_done", 1000);
      check("end_pc", pc, 32'd128);
      check("end_sb_empty", 32'(sb_q.size()), 32'h0);

      // Reset during WAIT_ALU of the second instruction.
      @(negedge CLK);
      load_basic();
      push_wb(32'h0, 32'h11);
      pulse_start();
      for (n = 0; n < 20 && !reg_we; n++) @(negedge CLK);
      alu_en = 1'b0;
      @(negedge CLK);
      for (n = 0; n < 20 && !alu_start; n++) @(negedge CLK);
      @(negedge CLK);
      check("mid_pc_before", pc, 32'h4);
      RSTn = 1'b0;
      #1;
      check("mid_rst_pc", pc, 32'h0);
      check("mid_rst_enable", 32'(enable), 32'h0);
      check("mid_rst_ir", ir, 32'h0);
      check("mid_rst_retired", 32'(retired), 32'h0);
      @(negedge CLK);
      RSTn = 1'b1;
      @(negedge CLK);
      alu_done_f = 1'b1;
      @(negedge CLK);
      alu_done_f = 1'b0;
      @(negedge CLK);
      check("idle_ignores_done", {enable, reg_we, pc[0]}, 32'h0);
      alu_en = 1'b1;
      n_start = 0; n_we = 0;
      push_wb(32'h0, 32'h11); push_wb(32'h4, 32'h22); push_wb(32'h8, 32'h33);
      push_halt(32'hC, 32'd3, 1'b0);
      pulse_start();
      wait_done("restart_done", 200);
      check("restart_reg_we", 32'(n_we), 32'd3);
      check("restart_sb_empty", 32'(sb_q.size()), 32'h0);

`ifdef SEQ_SINGLE_STEP_EN
      // Single step: park in STEP_WAIT after the first writeback.
      @(negedge CLK);
      step_auto = 1'b0;
      push_wb(32'h0, 32'h11); push_wb(32'h4, 32'h22); push_wb(32'h8, 32'h33);
      push_halt(32'hC, 32'd3, 1'b0);
      pulse_start();
      for (n = 0; n < 20 && !reg_we; n++) @(negedge CLK);
      @(negedge CLK);
      for (int i = 0; i < 10; i++) begin
         check("step_hold_pc", pc, 32'h4);
         check("step_hold_state", {enable, ir}, {1'b1, 32'h11});
         @(negedge CLK);
      end
      step_m = 1'b1;
      @(negedge CLK);
      step_m = 1'b0;
      @(negedge CLK);
      check("step_fetch", ir, 32'h22);
      step_auto = 1'b1;
      wait_done("step_done", 200);
      check("step_sb_empty", 32'(sb_q.size()), 32'h0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
